// File: rtl/twiddle_factor_rom.sv
// ---------------------------------------------------------------------------
// twiddle_factor_rom
//
// Purpose:
//   A 64-entry constant ROM of radix-64 FFT twiddle factors
//   W64^k = cos(2*pi*k/64) - j*sin(2*pi*k/64).
//   Each value is stored in two's-complement Q1.6 format as round(64*x),
//   with halves rounded away from zero. This gives the exact range -64..+64.
//   The output is registered, so there is one cycle of latency. A new
//   address is accepted on every cycle.
//
// Configuration macro:
//   TWIDDLE_CONJ_EN - when defined, the ROM returns the conjugate W64^-k
//                     for inverse-FFT use. The imaginary part changes sign
//                     and the real part is unchanged.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst_n      in   1   asynchronous active-low reset, clears outputs to 0
//   addr       in   6   twiddle index k, 0..63
//   twiddle_re out  8   signed real part of the selected factor (registered)
//   twiddle_im out  8   signed imaginary part of the selected factor (registered)
// ---------------------------------------------------------------------------
module twiddle_factor_rom (
    input  logic              clk,
    input  logic              rst_n,
    input  logic        [5:0] addr,
    output logic signed [7:0] twiddle_re,
    output logic signed [7:0] twiddle_im
);

    logic signed [7:0] w_re;
    logic signed [7:0] w_sin;
    logic signed [7:0] w_im;
    logic signed [7:0] r_re;
    logic signed [7:0] r_im;

    // Every entry is listed explicitly, as round(64*cos) and round(64*sin)
    // for its own k. No quadrant folding is used, so each value is the
    // correctly rounded one.
    always_comb begin
        w_re  = 8'sd0;
        w_sin = 8'sd0;
        case (addr)
            6'd0 : begin w_re =  8'sd64; w_sin =  8'sd0;  end
            6'd1 : begin w_re =  8'sd64; w_sin =  8'sd6;  end
            6'd2 : begin w_re =  8'sd63; w_sin =  8'sd12; end
            6'd3 : begin w_re =  8'sd61; w_sin =  8'sd19; end
            6'd4 : begin w_re =  8'sd59; w_sin =  8'sd24; end
            6'd5 : begin w_re =  8'sd56; w_sin =  8'sd30; end
            6'd6 : begin w_re =  8'sd53; w_sin =  8'sd36; end
            6'd7 : begin w_re =  8'sd49; w_sin =  8'sd41; end
            6'd8 : begin w_re =  8'sd45; w_sin =  8'sd45; end
            6'd9 : begin w_re =  8'sd41; w_sin =  8'sd49; end
            6'd10: begin w_re =  8'sd36; w_sin =  8'sd53; end
            6'd11: begin w_re =  8'sd30; w_sin =  8'sd56; end
            6'd12: begin w_re =  8'sd24; w_sin =  8'sd59; end
            6'd13: begin w_re =  8'sd19; w_sin =  8'sd61; end
            6'd14: begin w_re =  8'sd12; w_sin =  8'sd63; end
            6'd15: begin w_re =  8'sd6;  w_sin =  8'sd64; end
            6'd16: begin w_re =  8'sd0;  w_sin =  8'sd64; end
            6'd17: begin w_re = -8'sd6;  w_sin =  8'sd64; end
            6'd18: begin w_re = -8'sd12; w_sin =  8'sd63; end
            6'd19: begin w_re = -8'sd19; w_sin =  8'sd61; end
            6'd20: begin w_re = -8'sd24; w_sin =  8'sd59; end
            6'd21: begin w_re = -8'sd30; w_sin =  8'sd56; end
            6'd22: begin w_re = -8'sd36; w_sin =  8'sd53; end
            6'd23: begin w_re = -8'sd41; w_sin =  8'sd49; end
            6'd24: begin w_re = -8'sd45; w_sin =  8'sd45; end
            6'd25: begin w_re = -8'sd49; w_sin =  8'sd41; end
            6'd26: begin w_re = -8'sd53; w_sin =  8'sd36; end
            6'd27: begin w_re = -8'sd56; w_sin =  8'sd30; end
            6'd28: begin w_re = -8'sd59; w_sin =  8'sd24; end
            6'd29: begin w_re = -8'sd61; w_sin =  8'sd19; end
            6'd30: begin w_re = -8'sd63; w_sin =  8'sd12; end
            6'd31: begin w_re = -8'sd64; w_sin =  8'sd6;  end
            6'd32: begin w_re = -8'sd64; w_sin =  8'sd0;  end
            6'd33: begin w_re = -8'sd64; w_sin = -8'sd6;  end
            6'd34: begin w_re = -8'sd63; w_sin = -8'sd12; end
            6'd35: begin w_re = -8'sd61; w_sin = -8'sd19; end
            6'd36: begin w_re = -8'sd59; w_sin = -8'sd24; end
            6'd37: begin w_re = -8'sd56; w_sin = -8'sd30; end
            6'd38: begin w_re = -8'sd53; w_sin = -8'sd36; end
            6'd39: begin w_re = -8'sd49; w_sin = -8'sd41; end
            6'd40: begin w_re = -8'sd45; w_sin = -8'sd45; end
            6'd41: begin w_re = -8'sd41; w_sin = -8'sd49; end
            6'd42: begin w_re = -8'sd36; w_sin = -8'sd53; end
            6'd43: begin w_re = -8'sd30; w_sin = -8'sd56; end
            6'd44: begin w_re = -8'sd24; w_sin = -8'sd59; end
            6'd45: begin w_re = -8'sd19; w_sin = -8'sd61; end
            6'd46: begin w_re = -8'sd12; w_sin = -8'sd63; end
            6'd47: begin w_re = -8'sd6;  w_sin = -8'sd64; end
            6'd48: begin w_re =  8'sd0;  w_sin = -8'sd64; end
            6'd49: begin w_re =  8'sd6;  w_sin = -8'sd64; end
            6'd50: begin w_re =  8'sd12; w_sin = -8'sd63; end
            6'd51: begin w_re =  8'sd19; w_sin = -8'sd61; end
            6'd52: begin w_re =  8'sd24; w_sin = -8'sd59; end
            6'd53: begin w_re =  8'sd30; w_sin = -8'sd56; end
            6'd54: begin w_re =  8'sd36; w_sin = -8'sd53; end
            6'd55: begin w_re =  8'sd41; w_sin = -8'sd49; end
            6'd56: begin w_re =  8'sd45; w_sin = -8'sd45; end
            6'd57: begin w_re =  8'sd49; w_sin = -8'sd41; end
            6'd58: begin w_re =  8'sd53; w_sin = -8'sd36; end
            6'd59: begin w_re =  8'sd56; w_sin = -8'sd30; end
            6'd60: begin w_re =  8'sd59; w_sin = -8'sd24; end
            6'd61: begin w_re =  8'sd61; w_sin = -8'sd19; end
            6'd62: begin w_re =  8'sd63; w_sin = -8'sd12; end
            6'd63: begin w_re =  8'sd64; w_sin = -8'sd6;  end
            default: begin w_re = 8'sd0; w_sin = 8'sd0; end
        endcase
    end

    // The forward transform uses -sin and the inverse transform uses +sin.
    // The magnitudes never exceed 64, so negating the value cannot overflow.
`ifdef TWIDDLE_CONJ_EN
    assign w_im = w_sin;
`else
    assign w_im = -w_sin;
`endif

    // This is the only state in the design: one output register stage.
    // Reset clears it at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re <= 8'sd0;
            r_im <= 8'sd0;
        end else begin
            r_re <= w_re;
            r_im <= w_im;
        end
    end

    assign twiddle_re = r_re;
    assign twiddle_im = r_im;

endmodule

// File: tb/tb_twiddle_factor_rom.sv
// ---------------------------------------------------------------------------
// tb_twiddle_factor_rom
//
// Self-checking bench for twiddle_factor_rom. Expected values come from
// real-valued cos/sin, rounded half away from zero. The bench follows
// TWIDDLE_CONJ_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_twiddle_factor_rom;

    localparam real PI = 3.14159265358979323846;

    logic              clk;
    logic              rst_n;
    logic        [5:0] addr;
    logic signed [7:0] twiddle_re;
    logic signed [7:0] twiddle_im;

    int checks   = 0;
    int failures = 0;

    twiddle_factor_rom dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .twiddle_re (twiddle_re),
        .twiddle_im (twiddle_im)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the bench always ends, even if something stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Rounds half away from zero.
    function automatic int roundAway(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    function automatic int modelRe(input int k);
        return roundAway(64.0 * $cos(2.0 * PI * k / 64.0));
    endfunction

    function automatic int modelIm(input int k);
`ifdef TWIDDLE_CONJ_EN
        return roundAway(64.0 * $sin(2.0 * PI * k / 64.0));
`else
        return roundAway(-64.0 * $sin(2.0 * PI * k / 64.0));
`endif
    endfunction

    // Drives the address away from the active edge. It then returns 1 ns
    // after the rising edge, where the registered result can be sampled.
    task automatic applyStimulus(input int k);
        @(negedge clk);
        addr = k[5:0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int expRe, input int expIm);
        logic signed [31:0] obsRe;
        logic signed [31:0] obsIm;
        logic signed [31:0] wantRe;
        logic signed [31:0] wantIm;
        obsRe  = twiddle_re;
        obsIm  = twiddle_im;
        wantRe = expRe;
        wantIm = expIm;
        checks++;
        assert (obsRe === wantRe) else begin
            failures++;
            $error("[TB] FAIL %s.re observed=%0d expected=%0d", tag, obsRe, wantRe);
        end
        checks++;
        assert (obsIm === wantIm) else begin
            failures++;
            $error("[TB] FAIL %s.im observed=%0d expected=%0d", tag, obsIm, wantIm);
        end
        checks++;
        assert (obsRe !== -32'sd128 && obsIm !== -32'sd128) else begin
            failures++;
            $error("[TB] FAIL %s.range observed=(%0d,%0d) expected=not -128", tag, obsRe, obsIm);
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        addr  = 6'd5;

        // Hold reset with addr=5 across several edges. The outputs must stay 0.
        $display("[TB] reset hold");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("resetHold", 0, 0);
        end

        // Release reset. The first edge loads the current address.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("firstAfterReset", modelRe(5), modelIm(5));

        // Full sweep with one new address on every cycle.
        $display("[TB] sweep 0..63");
        for (int i = 0; i < 64; i++) begin
            applyStimulus(i);
            checkOutput($sformatf("sweep%0d", i), modelRe(i), modelIm(i));
        end

        // Spot values written out by hand.
        applyStimulus(4);
`ifdef TWIDDLE_CONJ_EN
        checkOutput("k4", 59, 24);
`else
        checkOutput("k4", 59, -24);
`endif
        applyStimulus(8);
`ifdef TWIDDLE_CONJ_EN
        checkOutput("k8", 45, 45);
`else
        checkOutput("k8", 45, -45);
`endif

        // Cardinal points.
        applyStimulus(0);
        checkOutput("card0", 64, 0);
        applyStimulus(16);
`ifdef TWIDDLE_CONJ_EN
        checkOutput("card16", 0, 64);
`else
        checkOutput("card16", 0, -64);
`endif
        applyStimulus(32);
        checkOutput("card32", -64, 0);
        applyStimulus(48);
`ifdef TWIDDLE_CONJ_EN
        checkOutput("card48", 0, -64);
`else
        checkOutput("card48", 0, 64);
`endif

        // Wrap from 63 to 0, then hold the address at 0 for several cycles.
        $display("[TB] wrap and hold");
        applyStimulus(63);
`ifdef TWIDDLE_CONJ_EN
        checkOutput("wrap63", 64, -6);
`else
        checkOutput("wrap63", 64, 6);
`endif
        applyStimulus(0);
        checkOutput("wrap0", 64, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold0", 64, 0);
        end

        // Random addresses, back to back.
        $display("[TB] random addresses");
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(63, 0);
            applyStimulus(k);
            checkOutput($sformatf("rand%0d_k%0d", i, k), modelRe(k), modelIm(k));
        end

        // Assert reset mid-sweep at addr=20, between clock edges.
        $display("[TB] mid-sweep reset");
        for (int i = 17; i <= 20; i++) begin
            applyStimulus(i);
            checkOutput($sformatf("pre%0d", i), modelRe(i), modelIm(i));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetAsync", 0, 0);
        @(posedge clk);
        #1;
        checkOutput("midResetHeld", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midResetRelease", modelRe(20), modelIm(20));
        for (int i = 21; i <= 26; i++) begin
            applyStimulus(i);
            checkOutput($sformatf("resume%0d", i), modelRe(i), modelIm(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
